// File: rtl/sds_frame_min.sv
// Framed minimum-distance reducer: folds a stream of (distance, state) candidates
// into the single surviving minimum per frame, with a selectable tie-break rule.
module sds_frame_min #(
   parameter int DIS_W    = 12,
   parameter int STATE_W  = 6,
   parameter int NUM_CAND = 64,
   parameter int TIE_LAST = 1,
   parameter int CNT_W    = $clog2(NUM_CAND + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               di_valid,
   output logic               di_ready,
   input  logic               di_first,
   input  logic               di_last,
   input  logic [DIS_W-1:0]   di_dis,
   input  logic [STATE_W-1:0] di_state,
   output logic               do_valid,
   input  logic               do_ready,
   output logic [DIS_W-1:0]   do_dis,
   output logic [STATE_W-1:0] do_state,
   output logic [CNT_W-1:0]   do_count,
   output logic               do_err
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_EXP  = CNT_W'(NUM_CAND);

   state_t               state_r, state_nxt_s;
   logic [DIS_W-1:0]     acc_dis_r, acc_dis_nxt_s;
   logic [STATE_W-1:0]   acc_state_r, acc_state_nxt_s;
   logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
   logic                 restart_r, restart_nxt_s;
   logic                 beat_s, open_s, replace_s, close_s;

   // A pending result that downstream has not taken blocks new beats.
   assign di_ready = !(do_valid && !do_ready);
   assign beat_s   = di_valid && di_ready;
   assign close_s  = beat_s && di_last;

   // Next-state and accumulator update for one accepted beat.
   always_comb begin
      state_nxt_s     = state_r;
      acc_dis_nxt_s   = acc_dis_r;
      acc_state_nxt_s = acc_state_r;
      cnt_nxt_s       = cnt_r;
      restart_nxt_s   = restart_r;
      open_s          = 1'b0;
      replace_s       = 1'b0;
      if (beat_s) begin
         case (state_r)
            IDLE:    open_s = 1'b1;
            ACC:     open_s = di_first;
            default: open_s = 1'b1;
         endcase
         if (open_s) begin
            acc_dis_nxt_s   = di_dis;
            acc_state_nxt_s = di_state;
            cnt_nxt_s       = CNT_ONE;
            restart_nxt_s   = (state_r == ACC);
         end else begin
            if (TIE_LAST != 0) begin
               replace_s = (di_dis <= acc_dis_r);
            end else begin
               replace_s = (di_dis < acc_dis_r);
            end
            if (replace_s) begin
               acc_dis_nxt_s   = di_dis;
               acc_state_nxt_s = di_state;
            end else begin
               acc_dis_nxt_s   = acc_dis_r;
               acc_state_nxt_s = acc_state_r;
            end
            if (cnt_r != CNT_MAX) begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         if (di_last) begin
            state_nxt_s = IDLE;
         end else begin
            state_nxt_s = ACC;
         end
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State, accumulator and result registers; closing a frame overrides consumption.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         acc_dis_r   <= {DIS_W{1'b0}};
         acc_state_r <= {STATE_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         restart_r   <= 1'b0;
         do_valid    <= 1'b0;
         do_dis      <= {DIS_W{1'b0}};
         do_state    <= {STATE_W{1'b0}};
         do_count    <= {CNT_W{1'b0}};
         do_err      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         acc_dis_r   <= acc_dis_nxt_s;
         acc_state_r <= acc_state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         restart_r   <= restart_nxt_s;
         if (close_s) begin
            do_valid <= 1'b1;
            do_dis   <= acc_dis_nxt_s;
            do_state <= acc_state_nxt_s;
            do_count <= cnt_nxt_s;
            do_err   <= (cnt_nxt_s != CNT_EXP) || restart_nxt_s;
         end else if (do_ready) begin
            do_valid <= 1'b0;
         end else begin
            do_valid <= do_valid;
         end
      end
   end

endmodule

// File: tb/tb_sds_frame_min.sv
// Directed bench for sds_frame_min: frame vectors from a table plus hand-written
// sequences for restart, backpressure, back-to-back results and mid-frame reset.
module tb_sds_frame_min;

   logic        clk = 1'b0;
   logic        rst;
   logic        di_valid, di_first, di_last, do_ready;
   logic [11:0] di_dis;
   logic [5:0]  di_state;

   logic        di_ready, do_valid, do_err;
   logic [11:0] do_dis;
   logic [5:0]  do_state;
   logic [6:0]  do_count;

   logic        di_ready0, do_valid0, do_err0;
   logic [11:0] do_dis0;
   logic [5:0]  do_state0;
   logic [6:0]  do_count0;

   int n_chk  = 0;
   int n_fail = 0;
   int hs_cnt = 0;

   always #5 clk = ~clk;

   sds_frame_min #(.DIS_W(12), .STATE_W(6), .NUM_CAND(64), .TIE_LAST(1)) dut (
      .clk(clk), .rst(rst), .di_valid(di_valid), .di_ready(di_ready),
      .di_first(di_first), .di_last(di_last), .di_dis(di_dis), .di_state(di_state),
      .do_valid(do_valid), .do_ready(do_ready), .do_dis(do_dis), .do_state(do_state),
      .do_count(do_count), .do_err(do_err)
   );

   sds_frame_min #(.DIS_W(12), .STATE_W(6), .NUM_CAND(64), .TIE_LAST(0)) dut0 (
      .clk(clk), .rst(rst), .di_valid(di_valid), .di_ready(di_ready0),
      .di_first(di_first), .di_last(di_last), .di_dis(di_dis), .di_state(di_state),
      .do_valid(do_valid0), .do_ready(do_ready), .do_dis(do_dis0), .do_state(do_state0),
      .do_count(do_count0), .do_err(do_err0)
   );

   // Count results actually handed downstream by the main instance.
   always @(posedge clk) begin
      if (!rst && do_valid && do_ready) hs_cnt <= hs_cnt + 1;
   end

   typedef struct {
      int          n;
      int          base;
      int          step;
      int          sbase;
      logic [11:0] exp_dis;
      logic [5:0]  exp_st1;
      logic [5:0]  exp_st0;
      logic [6:0]  exp_cnt;
      logic        exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Beat i of a frame carries dis = base + step*i, state = sbase + i (both wrapping).
   task automatic drive_beats(input int start, input int n, input int base, input int step,
                              input int sbase, input bit close);
      for (int i = start; i < n; i++) begin
         di_valid = 1'b1;
         di_first = (i == 0);
         di_last  = close && (i == n - 1);
         di_dis   = 12'(base + step * i);
         di_state = 6'(sbase + i);
         @(posedge clk); #1;
      end
   endtask

   task automatic idle_cycle();
      di_valid = 1'b0;
      di_first = 1'b0;
      di_last  = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int h0;
      vecs[0] = '{64,  100, -1,  0, 12'd37,   6'd63, 6'd63, 7'd64, 1'b0};
      vecs[1] = '{64,    5,  0,  0, 12'd5,    6'd63, 6'd0,  7'd64, 1'b0};
      vecs[2] = '{1, 'hABC,  0,  9, 12'hABC,  6'd9,  6'd9,  7'd1,  1'b1};
      vecs[3] = '{32,  200,  3,  0, 12'd200,  6'd0,  6'd0,  7'd32, 1'b1};
      vecs[4] = '{65, 1000, -2,  0, 12'd872,  6'd0,  6'd0,  7'd65, 1'b1};
      vecs[5] = '{64, 4095, -1,  5, 12'd4032, 6'd4,  6'd4,  7'd64, 1'b0};

      rst = 1'b1; di_valid = 1'b0; di_first = 1'b0; di_last = 1'b0;
      di_dis = 12'd0; di_state = 6'd0; do_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst_valid", {31'd0, do_valid}, 32'd0);
      check("rst_dis",   {20'd0, do_dis},   32'd0);
      check("rst_state", {26'd0, do_state}, 32'd0);
      check("rst_count", {25'd0, do_count}, 32'd0);
      check("rst_err",   {31'd0, do_err},   32'd0);
      check("rst_ready", {31'd0, di_ready}, 32'd1);
      check("rst_valid0", {31'd0, do_valid0}, 32'd0);
      check("rst_ready0", {31'd0, di_ready0}, 32'd1);

      do_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         h0 = hs_cnt;
         drive_beats(0, vecs[k].n, vecs[k].base, vecs[k].step, vecs[k].sbase, 1'b1);
         check($sformatf("v%0d_valid", k),  {31'd0, do_valid},  32'd1);
         check($sformatf("v%0d_dis", k),    {20'd0, do_dis},    {20'd0, vecs[k].exp_dis});
         check($sformatf("v%0d_state", k),  {26'd0, do_state},  {26'd0, vecs[k].exp_st1});
         check($sformatf("v%0d_count", k),  {25'd0, do_count},  {25'd0, vecs[k].exp_cnt});
         check($sformatf("v%0d_err", k),    {31'd0, do_err},    {31'd0, vecs[k].exp_err});
         check($sformatf("v%0d_dis0", k),   {20'd0, do_dis0},   {20'd0, vecs[k].exp_dis});
         check($sformatf("v%0d_state0", k), {26'd0, do_state0}, {26'd0, vecs[k].exp_st0});
         idle_cycle();
         check($sformatf("v%0d_results", k), hs_cnt, h0 + 1);
         check($sformatf("v%0d_cleared", k), {31'd0, do_valid}, 32'd0);
      end

      // Back-to-back single-beat frames: consume and reload on the same edge.
      h0 = hs_cnt;
      drive_beats(0, 1, 'h111, 0, 3, 1'b1);
      check("b2b_a_dis", {20'd0, do_dis}, 32'h111);
      drive_beats(0, 1, 'h222, 0, 4, 1'b1);
      check("b2b_b_valid", {31'd0, do_valid}, 32'd1);
      check("b2b_b_dis",   {20'd0, do_dis},   32'h222);
      check("b2b_b_state", {26'd0, do_state}, 32'd4);
      check("b2b_b_count", {25'd0, do_count}, 32'd1);
      idle_cycle();
      check("b2b_results", hs_cnt, h0 + 2);

      // Restart: a partial frame is discarded when di_first arrives mid-frame.
      h0 = hs_cnt;
      drive_beats(0, 10, 1, 0, 7, 1'b0);
      check("rs_no_result", hs_cnt, h0);
      drive_beats(0, 64, 100, -1, 0, 1'b1);
      check("rs_dis",   {20'd0, do_dis},   32'd37);
      check("rs_state", {26'd0, do_state}, 32'd63);
      check("rs_count", {25'd0, do_count}, 32'd64);
      check("rs_err",   {31'd0, do_err},   32'd1);
      idle_cycle();
      check("rs_results", hs_cnt, h0 + 1);

      // Backpressure: first beat of the next frame waits while the result is held.
      drive_beats(0, 64, 100, -1, 0, 1'b1);
      do_ready = 1'b0;
      di_valid = 1'b1; di_first = 1'b1; di_last = 1'b0;
      di_dis = 12'd100; di_state = 6'd3;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("bp%0d_ready", c), {31'd0, di_ready}, 32'd0);
         check($sformatf("bp%0d_valid", c), {31'd0, do_valid}, 32'd1);
         check($sformatf("bp%0d_dis", c),   {20'd0, do_dis},   32'd37);
      end
      do_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_consumed", {31'd0, do_valid}, 32'd0);
      drive_beats(1, 64, 100, -1, 3, 1'b1);
      check("bp_dis",   {20'd0, do_dis},   32'd37);
      check("bp_state", {26'd0, do_state}, 32'd2);
      check("bp_count", {25'd0, do_count}, 32'd64);
      check("bp_err",   {31'd0, do_err},   32'd0);
      idle_cycle();

      // Reset mid-frame, with a closing beat on the reset edge itself.
      h0 = hs_cnt;
      drive_beats(0, 32, 500, -1, 0, 1'b0);
      rst = 1'b1;
      di_valid = 1'b1; di_first = 1'b0; di_last = 1'b1; di_dis = 12'd0; di_state = 6'd1;
      @(posedge clk); #1;
      check("mr_valid", {31'd0, do_valid}, 32'd0);
      check("mr_dis",   {20'd0, do_dis},   32'd0);
      check("mr_state", {26'd0, do_state}, 32'd0);
      check("mr_count", {25'd0, do_count}, 32'd0);
      check("mr_err",   {31'd0, do_err},   32'd0);
      rst = 1'b0;
      idle_cycle();
      check("mr_no_result", hs_cnt, h0);
      drive_beats(0, 64, 100, -1, 0, 1'b1);
      check("mr_dis2",   {20'd0, do_dis},   32'd37);
      check("mr_state2", {26'd0, do_state}, 32'd63);
      check("mr_count2", {25'd0, do_count}, 32'd64);
      check("mr_err2",   {31'd0, do_err},   32'd0);
      idle_cycle();
      check("mr_results", hs_cnt, h0 + 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sds_frame_min.md
# sds_frame_min

Streaming, parametrised successor to the smaller-distance-select unit. It accepts one (distance, state) candidate per cycle over a framed stream and reduces the whole frame to the single surviving minimum-distance state, with a selectable tie-break rule. It sits between the Viterbi add-compare-select array and the traceback unit, and it provides the traceback start state once per decoded block. Ready/valid handshakes on both sides let it absorb backpressure from traceback.

## Interface
Parameters:
- DIS_W, 12, distance (path metric) width, unsigned
- STATE_W, 6, state index width
- NUM_CAND, 64, expected candidates per frame; mismatch raises do_err
- TIE_LAST, 1, tie-break rule: 1 = later candidate wins on equal distance; 0 = earlier candidate is kept
- CNT_W, $clog2(NUM_CAND+1), candidate counter width (derived, never overridden)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- di_valid  in  1  candidate valid
- di_ready  out  1  block can accept a candidate
- di_first  in  1  candidate is the first of a frame
- di_last  in  1  candidate is the last of a frame
- di_dis  in  DIS_W  candidate distance
- di_state  in  STATE_W  candidate state index
- do_valid  out  1  frame result valid
- do_ready  in  1  downstream accepts the result
- do_dis  out  DIS_W  minimum distance of the frame
- do_state  out  STATE_W  state holding that minimum
- do_count  out  CNT_W  candidates accepted in the frame (saturating at all-ones)
- do_err  out  1  frame length differed from NUM_CAND, or the frame was restarted mid-way

## Operation
- Beat accepted when di_valid && di_ready. di_ready = !(do_valid && !do_ready) (combinational).
- FSM states: IDLE (no open frame), ACC (frame open). Transitions below apply only to accepted beats.
- Beat in IDLE: opens a frame whether or not di_first is set. The accumulator loads di_dis/di_state, count = 1, restart flag = 0, and the FSM goes to ACC. If di_last is also set, the frame closes on the same beat (single-candidate frame).
- Beat in ACC without di_first:
  - TIE_LAST=1: replace when di_dis <= acc_dis.
  - TIE_LAST=0: replace when di_dis < acc_dis.
  - Count increments, saturating.
- Beat in ACC with di_first: the open frame is discarded and produces no output. The accumulator reloads as in IDLE, count = 1, and the restart flag is set.
- Beat with di_last closes the frame. The final (dis, state), including the last beat's compare, is registered into do_dis/do_state. do_count = final count. do_err = (final count != NUM_CAND) || restart flag. do_valid = 1 and the FSM returns to IDLE.
- Output register holds until do_valid && do_ready, then do_valid clears. Output data values are retained until overwritten.
- Compare is unsigned and full-width. There is no arithmetic on distances.

## Timing
- Reset (synchronous, rst high at edge): FSM = IDLE, do_valid = 0, do_dis = 0, do_state = 0, do_count = 0, do_err = 0, restart flag = 0. Accumulator contents are don't-care. rst has priority over every other event, including a beat on the same edge. A frame open at reset is lost without output.
- Latency: do_valid rises on the edge that accepts the di_last beat, so it is visible the following cycle.
- Back-to-back frames: a new frame's first beat may be accepted the cycle after di_last while do_valid is high, provided do_ready is high in that cycle.
- Result pending and do_ready low: di_ready = 0 and no beats are accepted. The accumulator and FSM hold.
- do_ready with do_valid low: ignored.
- Simultaneous do_ready and di_last beat (possible only when do_valid is high and do_ready is high): the old result is consumed and the new result loads on the same edge, so do_valid stays 1.
- di_valid low mid-frame: no state change (gaps allowed).

## Test plan
- Reset then 64-beat frame, di_dis = 100-i for i=0..63, state = i -> one do_valid, do_dis=37, do_state=63, do_count=64, do_err=0.
- Frame of 64 beats, all distances 5, TIE_LAST=1 -> do_state=63. Same frame with TIE_LAST=0 -> do_state=0.
- Single beat with di_first and di_last, dis=0xABC, state=9 -> next cycle do_valid=1, do_dis=0xABC, do_state=9, do_count=1, do_err=1.
- 10 beats, then di_first again, then a full 64-beat frame -> exactly one result, computed over the 64-beat frame only, with do_count=64 and do_err=1.
- Hold do_ready=0 for 5 cycles after a result, with di_valid=1 continuously -> di_ready=0 throughout, outputs stable, no beats lost. Then do_ready=1 -> the next frame proceeds and produces a correct result.
- Assert rst in the middle of frame 32 -> all outputs zero, no result emitted. The following full frame produces a correct result with do_err=0.
